gmii_rx_mac: RTL



---
 rtl/gmii_pkg.sv | 25 ++
 rtl/eth_crc32_d8.sv | 19 +
 rtl/gmii_rx_mac.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared types and constants for the GMII receive MAC
// Contents: rx_state_t FSM encoding, preamble/SFD bytes, CRC32 constants,
//           rx_status_t per-frame status word {crc_err, len_err, phy_err}.
package gmii_pkg;

    typedef enum logic [1:0] {
        DROP = 2'd0,
        IDLE = 2'd1,
        PRE  = 2'd2,
        PAY  = 2'd3
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef struct packed {
        logic crc_err;
        logic len_err;
        logic phy_err;
    } rx_status_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational Ethernet CRC32 update for one byte
// Ports: crc (current register), data (byte, bit 0 enters first),
//        crc_next (register after the byte). Reflected form, no inversion.
module eth_crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            crc_next = (crc_next >> 1) ^ (CRC_POLY & {32{crc_next[0] ^ data[i]}});
        end
    end

endmodule

// File: rtl/gmii_rx_mac.sv
// rtl/gmii_rx_mac.sv - GMII receive framer: strips preamble/SFD/FCS, checks CRC and length
// Ports: clk, arst (async, active-high); rxd/rxdv/rxer from the PHY;
//        m_data/m_valid/m_sof/m_eof/m_status payload stream (no backpressure).
// Optional: define GMII_RX_STATS_EN to add stat_frames/stat_crc_err/stat_len_err.
module gmii_rx_mac
    import gmii_pkg::*;
#(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [7:0]  rxd,
    input  logic        rxdv,
    input  logic        rxer,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sof,
    output logic        m_eof,
    output logic [2:0]  m_status
`ifdef GMII_RX_STATS_EN
    ,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_crc_err,
    output logic [31:0] stat_len_err
`endif
);

    localparam int CW = $clog2(MAX_FRAME + 2);
    localparam logic [CW-1:0] N_MIN  = CW'(MIN_FRAME);
    localparam logic [CW-1:0] N_MAX  = CW'(MAX_FRAME);
    localparam logic [CW-1:0] N_HELD = CW'(5);

    rx_state_t       state;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic [4:0][7:0] dl;        // dl[0] newest, dl[4] oldest
    logic [CW-1:0]   cnt;
    logic            phy_seen;
    logic            sof_pend;

    // Emission stage; the extra register after the delay line sets the 6-clk latency.
    logic            e_valid;
    logic            e_sof;
    logic            e_eof;
    logic [7:0]      e_data;
    rx_status_t      e_status;
`ifdef GMII_RX_STATS_EN
    logic            e_runt;
`endif

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (rxd),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= DROP;
            crc      <= CRC_INIT;
            dl       <= '0;
            cnt      <= '0;
            phy_seen <= 1'b0;
            sof_pend <= 1'b0;
            e_valid  <= 1'b0;
            e_sof    <= 1'b0;
            e_eof    <= 1'b0;
            e_data   <= '0;
            e_status <= '0;
`ifdef GMII_RX_STATS_EN
            e_runt   <= 1'b0;
`endif
        end else begin
            e_valid  <= 1'b0;
            e_sof    <= 1'b0;
            e_eof    <= 1'b0;
            e_data   <= '0;
            e_status <= '0;
`ifdef GMII_RX_STATS_EN
            e_runt   <= 1'b0;
`endif
            case (state)
                DROP: begin
                    if (!rxdv) state <= IDLE;
                end
                IDLE, PRE: begin
                    if (!rxdv) begin
                        state <= IDLE;
                    end else if (state == PRE && rxer) begin
                        state <= DROP;
                    end else if (rxd == SFD) begin
                        state    <= PAY;
                        crc      <= CRC_INIT;
                        cnt      <= '0;
                        phy_seen <= 1'b0;
                        sof_pend <= 1'b1;
                    end else if (rxd == PREAMBLE) begin
                        state <= PRE;
                    end else begin
                        state <= DROP;
                    end
                end
                PAY: begin
                    if (rxdv) begin
                        crc      <= crc_next;
                        dl       <= {dl[3:0], rxd};
                        phy_seen <= phy_seen | rxer;
                        if (cnt != N_MAX + 1'b1) cnt <= cnt + 1'b1;
                        if (cnt >= N_HELD) begin
                            e_valid  <= 1'b1;
                            e_data   <= dl[4];
                            e_sof    <= sof_pend;
                            sof_pend <= 1'b0;
                            // This byte makes the frame MAX_FRAME+1 long: close it as oversize.
                            if (cnt == N_MAX) begin
                                e_eof    <= 1'b1;
                                e_status <= rx_status_t'{crc_err: 1'b0, len_err: 1'b1,
                                                         phy_err: phy_seen | rxer};
                                state    <= DROP;
                            end
                        end
                    end else begin
                        state <= IDLE;
                        if (cnt >= N_HELD) begin
                            // dl[4] is the last data byte; dl[3:0] are the FCS.
                            e_valid  <= 1'b1;
                            e_data   <= dl[4];
                            e_sof    <= sof_pend;
                            e_eof    <= 1'b1;
                            e_status <= rx_status_t'{crc_err: crc != CRC_RESIDUE,
                                                     len_err: cnt < N_MIN,
                                                     phy_err: phy_seen};
                        end else begin
`ifdef GMII_RX_STATS_EN
                            e_runt <= 1'b1;
`endif
                        end
                    end
                end
                default: state <= DROP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
            m_status <= '0;
        end else begin
            m_data   <= e_data;
            m_valid  <= e_valid;
            m_sof    <= e_sof;
            m_eof    <= e_eof;
            m_status <= e_status;
        end
    end

`ifdef GMII_RX_STATS_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stat_frames  <= '0;
            stat_crc_err <= '0;
            stat_len_err <= '0;
        end else begin
            if (e_valid && e_eof) begin
                stat_frames <= stat_frames + 1'b1;
                if (e_status.crc_err) stat_crc_err <= stat_crc_err + 1'b1;
            end
            if ((e_valid && e_eof && e_status.len_err) || e_runt)
                stat_len_err <= stat_len_err + 1'b1;
        end
    end
`endif

endmodule
